// File: rtl/dm_if.sv
// Request/response bundle between the MEM stage and dm_ctrl; master = CPU side, slave = memory.
interface dm_if #(
  parameter int ADDR_W = 12
);
  logic              req;
  logic              we;
  logic [1:0]        size;
  logic              sign_ext;
  logic [ADDR_W-1:0] addr;
  logic [31:0]       wdata;
  logic              ready;
  logic              rvalid;
  logic [31:0]       rdata;
  logic              err;

  modport master (
    output req, we, size, sign_ext, addr, wdata,
    input  ready, rvalid, rdata, err
  );

  modport slave (
    input  req, we, size, sign_ext, addr, wdata,
    output ready, rvalid, rdata, err
  );
endinterface

// File: rtl/dm_ctrl.sv
// Byte-addressable data memory: stores commit on the accepting edge, loads return one cycle later; ready=0 while clearing.
// DM_ALIGN_CHK_EN: misaligned halfword/word accesses are suppressed and flagged on err.
module dm_ctrl #(
  parameter int ADDR_W       = 12,
  parameter bit CLR_ON_RESET = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  dm_if.slave  bus
);
  localparam int IW    = ADDR_W - 2;
  localparam int DEPTH = 2 ** IW;

  typedef enum logic {S_CLEAR, S_IDLE} state_t;

  state_t          r_state, w_state_nxt;
  logic            r_ready, w_ready_nxt;
  logic [IW-1:0]   r_clr_cnt;
  logic            w_clr_we;

  logic [31:0]     r_mem [DEPTH];

  logic            w_acc;
  logic            w_mis;
  logic [IW-1:0]   w_idx;
  logic [3:0]      w_be;
  logic [31:0]     w_wdat;

  logic            r_rvalid;
  logic [31:0]     r_word;
  logic [1:0]      r_size;
  logic [1:0]      r_off;
  logic            r_sext;
  logic [7:0]      w_byte;
  logic [15:0]     w_half;
  logic [31:0]     w_rdata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= CLR_ON_RESET ? S_CLEAR : S_IDLE;
      r_ready   <= 1'b0;
      r_clr_cnt <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_ready <= w_ready_nxt;
      if (w_clr_we) r_clr_cnt <= r_clr_cnt + 1'b1;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_ready_nxt = r_ready;
    w_clr_we    = 1'b0;
    case (r_state)
      S_CLEAR: begin
        w_clr_we    = 1'b1;
        w_ready_nxt = 1'b0;
        if (&r_clr_cnt) begin
          w_state_nxt = S_IDLE;
          w_ready_nxt = 1'b1;
        end
      end
      S_IDLE:  w_ready_nxt = 1'b1;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign w_acc = r_ready & bus.req;
  assign w_idx = bus.addr[ADDR_W-1:2];

`ifdef DM_ALIGN_CHK_EN
  assign w_mis = ((bus.size == 2'b01) & bus.addr[0]) |
                 (bus.size[1] & (bus.addr[1:0] != 2'b00));
`else
  assign w_mis = 1'b0;
`endif

  // Store data is replicated across lanes so the byte enables alone pick the target bytes.
  always_comb begin
    w_be   = 4'b1111;
    w_wdat = bus.wdata;
    case (bus.size)
      2'b00: begin
        w_be   = 4'b0001 << bus.addr[1:0];
        w_wdat = {4{bus.wdata[7:0]}};
      end
      2'b01: begin
        w_be   = bus.addr[1] ? 4'b1100 : 4'b0011;
        w_wdat = {2{bus.wdata[15:0]}};
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_clr_we) begin
      r_mem[r_clr_cnt] <= '0;
    end else if (w_acc && bus.we && !w_mis) begin
      for (int i = 0; i < 4; i++) begin
        if (w_be[i]) r_mem[w_idx][8*i +: 8] <= w_wdat[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rvalid <= 1'b0;
      r_word   <= '0;
      r_size   <= 2'b10;
      r_off    <= 2'b00;
      r_sext   <= 1'b0;
    end else begin
      r_rvalid <= w_acc & ~bus.we;
      if (w_acc && !bus.we) begin
        r_word <= w_mis ? 32'h0 : r_mem[w_idx];
        r_size <= bus.size;
        r_off  <= bus.addr[1:0];
        r_sext <= bus.sign_ext;
      end
    end
  end

`ifdef DM_ALIGN_CHK_EN
  logic r_err;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_err <= 1'b0;
    else        r_err <= w_acc & w_mis;
  end
  assign bus.err = r_err;
`else
  assign bus.err = 1'b0;
`endif

  always_comb begin
    w_byte  = r_word[{r_off, 3'b000} +: 8];
    w_half  = r_off[1] ? r_word[31:16] : r_word[15:0];
    w_rdata = r_word;
    case (r_size)
      2'b00:   w_rdata = {{24{r_sext & w_byte[7]}}, w_byte};
      2'b01:   w_rdata = {{16{r_sext & w_half[15]}}, w_half};
      default: w_rdata = r_word;
    endcase
  end

  assign bus.ready  = r_ready;
  assign bus.rvalid = r_rvalid;
  assign bus.rdata  = w_rdata;
endmodule

// File: tb/tb_dm_ctrl.sv
// Directed bench for dm_ctrl: vector table for single accesses plus hand sequences for clear, pipelining and alignment.
module tb_dm_ctrl;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  dm_if #(.ADDR_W(12)) bus ();
  dm_ctrl #(.ADDR_W(12), .CLR_ON_RESET(1'b1)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic        sext;
    logic [11:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  function automatic vec_t mk(input logic we, input logic [1:0] size, input logic sext,
                              input logic [11:0] addr, input logic [31:0] wdata,
                              input logic [31:0] exp);
    vec_t t;
    t.we = we; t.size = size; t.sext = sext; t.addr = addr; t.wdata = wdata; t.exp = exp;
    return t;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h want 0x%08h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic we, input logic [1:0] size, input logic sext,
                       input logic [11:0] addr, input logic [31:0] wdata);
    bus.req      = 1'b1;
    bus.we       = we;
    bus.size     = size;
    bus.sign_ext = sext;
    bus.addr     = addr;
    bus.wdata    = wdata;
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge with req dropped.
  task automatic op(input logic we, input logic [1:0] size, input logic sext,
                    input logic [11:0] addr, input logic [31:0] wdata);
    drive(we, size, sext, addr, wdata);
    @(posedge clk);
    @(negedge clk);
    bus.req = 1'b0;
  endtask

  task automatic idle();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic run_clear(output int cyc);
    cyc = 0;
    while (cyc < 3000) begin
      @(posedge clk);
      #1;
      cyc++;
      if (bus.ready === 1'b1) break;
    end
    @(negedge clk);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int c;
    bus.req = 1'b0; bus.we = 1'b0; bus.size = 2'b10; bus.sign_ext = 1'b0;
    bus.addr = '0; bus.wdata = '0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_ready",  {31'b0, bus.ready},  32'h0);
    chk("reset_rvalid", {31'b0, bus.rvalid}, 32'h0);
    chk("reset_rdata",  bus.rdata,           32'h0);
    chk("reset_err",    {31'b0, bus.err},    32'h0);

    rst_n = 1'b1;
    run_clear(c);
    chk("clear_cycles", c, 32'd1024);

    op(1'b1, 2'b10, 1'b0, 12'h000, 32'hFFFFFFFF);
    op(1'b1, 2'b10, 1'b0, 12'hFFC, 32'hFFFFFFFF);

    // Interrupt the clear once the counter reaches 500; it must start over.
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (500) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    chk("midclear_ready", {31'b0, bus.ready}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    run_clear(c);
    chk("restart_cycles", c, 32'd1024);
    op(1'b0, 2'b10, 1'b0, 12'h000, 32'h0);
    chk("cleared_000", bus.rdata, 32'h0);
    op(1'b0, 2'b10, 1'b0, 12'hFFC, 32'h0);
    chk("cleared_ffc", bus.rdata, 32'h0);

    vecs.push_back(mk(1'b1, 2'b10, 1'b0, 12'h010, 32'h11223344, 32'h0));
    vecs.push_back(mk(1'b1, 2'b00, 1'b0, 12'h011, 32'h000000AB, 32'h0));
    vecs.push_back(mk(1'b0, 2'b10, 1'b0, 12'h010, 32'h0,        32'h1122AB44));
    vecs.push_back(mk(1'b1, 2'b10, 1'b0, 12'h020, 32'h80FF7F01, 32'h0));
    vecs.push_back(mk(1'b0, 2'b00, 1'b1, 12'h022, 32'h0,        32'hFFFFFFFF));
    vecs.push_back(mk(1'b0, 2'b00, 1'b0, 12'h022, 32'h0,        32'h000000FF));
    vecs.push_back(mk(1'b0, 2'b01, 1'b1, 12'h022, 32'h0,        32'hFFFF80FF));
    vecs.push_back(mk(1'b0, 2'b00, 1'b1, 12'h020, 32'h0,        32'h00000001));
    vecs.push_back(mk(1'b0, 2'b00, 1'b1, 12'h021, 32'h0,        32'h0000007F));
    vecs.push_back(mk(1'b0, 2'b00, 1'b1, 12'h023, 32'h0,        32'hFFFFFF80));
    vecs.push_back(mk(1'b0, 2'b01, 1'b1, 12'h020, 32'h0,        32'h00007F01));
    vecs.push_back(mk(1'b0, 2'b01, 1'b0, 12'h022, 32'h0,        32'h000080FF));
    vecs.push_back(mk(1'b1, 2'b01, 1'b0, 12'h032, 32'h0000BEEF, 32'h0));
    vecs.push_back(mk(1'b1, 2'b00, 1'b0, 12'h030, 32'h1234565A, 32'h0));
    vecs.push_back(mk(1'b0, 2'b10, 1'b0, 12'h030, 32'h0,        32'hBEEF005A));
    vecs.push_back(mk(1'b0, 2'b11, 1'b1, 12'h030, 32'h0,        32'hBEEF005A));
    vecs.push_back(mk(1'b0, 2'b10, 1'b0, 12'hFFC, 32'h0,        32'h00000000));
`ifndef DM_ALIGN_CHK_EN
    vecs.push_back(mk(1'b0, 2'b01, 1'b1, 12'h023, 32'h0,        32'hFFFF80FF));
    vecs.push_back(mk(1'b0, 2'b10, 1'b0, 12'h033, 32'h0,        32'hBEEF005A));
`endif

    for (int i = 0; i < vecs.size(); i++) begin
      op(vecs[i].we, vecs[i].size, vecs[i].sext, vecs[i].addr, vecs[i].wdata);
      if (!vecs[i].we) begin
        chk($sformatf("vec%0d_rvalid", i), {31'b0, bus.rvalid}, 32'h1);
        chk($sformatf("vec%0d_rdata", i),  bus.rdata,           vecs[i].exp);
      end else begin
        chk($sformatf("vec%0d_rvalid", i), {31'b0, bus.rvalid}, 32'h0);
      end
      chk($sformatf("vec%0d_err", i), {31'b0, bus.err}, 32'h0);
      idle();
      chk($sformatf("vec%0d_pulse", i), {31'b0, bus.rvalid}, 32'h0);
      if (!vecs[i].we) chk($sformatf("vec%0d_hold", i), bus.rdata, vecs[i].exp);
    end

    // Three loads on consecutive edges.
    drive(1'b0, 2'b10, 1'b0, 12'h010, 32'h0);
    @(posedge clk); @(negedge clk);
    chk("b2b0_rvalid", {31'b0, bus.rvalid}, 32'h1);
    chk("b2b0_rdata",  bus.rdata,           32'h1122AB44);
    chk("b2b0_ready",  {31'b0, bus.ready},  32'h1);
    drive(1'b0, 2'b10, 1'b0, 12'h020, 32'h0);
    @(posedge clk); @(negedge clk);
    chk("b2b1_rvalid", {31'b0, bus.rvalid}, 32'h1);
    chk("b2b1_rdata",  bus.rdata,           32'h80FF7F01);
    chk("b2b1_ready",  {31'b0, bus.ready},  32'h1);
    drive(1'b0, 2'b10, 1'b0, 12'h030, 32'h0);
    @(posedge clk); @(negedge clk);
    bus.req = 1'b0;
    chk("b2b2_rvalid", {31'b0, bus.rvalid}, 32'h1);
    chk("b2b2_rdata",  bus.rdata,           32'hBEEF005A);
    idle();
    chk("b2b_end_rvalid", {31'b0, bus.rvalid}, 32'h0);

    // Load immediately after a store to the same word.
    drive(1'b1, 2'b10, 1'b0, 12'h040, 32'hCAFEF00D);
    @(posedge clk); @(negedge clk);
    chk("st_ld_store_rvalid", {31'b0, bus.rvalid}, 32'h0);
    drive(1'b0, 2'b10, 1'b0, 12'h040, 32'h0);
    @(posedge clk); @(negedge clk);
    bus.req = 1'b0;
    chk("st_ld_rvalid", {31'b0, bus.rvalid}, 32'h1);
    chk("st_ld_rdata",  bus.rdata,           32'hCAFEF00D);

`ifdef DM_ALIGN_CHK_EN
    op(1'b1, 2'b10, 1'b0, 12'h040, 32'h12345678);
    chk("al_store_err", {31'b0, bus.err}, 32'h0);
    op(1'b1, 2'b10, 1'b0, 12'h042, 32'hDEADBEEF);
    chk("mis_store_err",    {31'b0, bus.err},    32'h1);
    chk("mis_store_rvalid", {31'b0, bus.rvalid}, 32'h0);
    idle();
    chk("mis_store_err_pulse", {31'b0, bus.err}, 32'h0);
    op(1'b0, 2'b10, 1'b0, 12'h040, 32'h0);
    chk("mis_store_unchanged", bus.rdata, 32'h12345678);
    op(1'b0, 2'b01, 1'b1, 12'h041, 32'h0);
    chk("mis_load_rvalid", {31'b0, bus.rvalid}, 32'h1);
    chk("mis_load_err",    {31'b0, bus.err},    32'h1);
    chk("mis_load_rdata",  bus.rdata,           32'h0);
    idle();
    chk("mis_load_err_pulse", {31'b0, bus.err}, 32'h0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/dm_ctrl.md
Name: dm_ctrl

Overview:
- Parametrised, byte-addressable data memory with a registered read port and a request/ready handshake.
- Successor to the fixed 4 KB word-only data memory.
- Adds:
  - byte, halfword and word stores using byte lanes
  - sign-extending and zero-extending sub-word loads
  - a post-reset hardware clear sequence
- Sits in the MEM stage of the pipelined CPU; the hazard unit stalls on !ready.

Parameters:
- ADDR_W, 12, byte-address width; memory depth = 2^(ADDR_W-2) 32-bit words.
- CLR_ON_RESET, 1, 1 = zero every word after reset (takes DEPTH cycles); 0 = skip the clear and contents are undefined after reset.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req  in  1  access request; qualified by ready.
- we  in  1  1 = store, 0 = load.
- size  in  2  00 = byte, 01 = halfword, 10 = word, 11 = treated as word.
- sign_ext  in  1  loads only: 1 = sign-extend sub-word, 0 = zero-extend.
- addr  in  ADDR_W  byte address.
- wdata  in  32  store data, right-aligned (byte in [7:0], halfword in [15:0]).
- ready  out  1  block can accept a request this cycle.
- rvalid  out  1  one-cycle pulse: rdata is valid.
- rdata  out  32  extended load result.
- err  out  1  misaligned-access pulse (only with the optional feature).

Behaviour:
- Reset (rst_n=0, async):
  - ready=0, rvalid=0, rdata=0, err=0, clear counter=0.
  - Next state is CLEAR if CLR_ON_RESET=1, else IDLE.
- States: CLEAR, IDLE.
- CLEAR:
  - One word written to zero per cycle at index = counter; counter increments.
  - ready=0 throughout; req is ignored.
  - After the word at index DEPTH-1 is written: go to IDLE, ready=1 from the next cycle.
  - Reset asserted mid-clear restarts the clear from index 0.
- IDLE (ready=1): an access is accepted on any edge with req=1.
- Store accepted:
  - Only the selected lanes of word addr[ADDR_W-1:2] are written, on that edge; other bytes are unchanged.
  - Byte: lane addr[1:0] gets wdata[7:0].
  - Halfword: lanes {addr[1],0} and {addr[1],1} get wdata[15:0], low byte to the lower lane (little-endian).
  - Word: all four lanes get wdata.
  - No rvalid pulse.
- Load accepted:
  - The word and the extraction controls (size, addr[1:0], sign_ext) are registered.
  - rvalid=1 in the following cycle for exactly one cycle.
  - rdata = the selected byte or halfword, extended per sign_ext; a word load returns the full word.
- Throughput and ordering:
  - One access per cycle; back-to-back loads give back-to-back rvalid.
  - A load in the cycle right after a store to the same word returns the stored data.
- rdata holds its last value while rvalid=0. rvalid=0 in any cycle following a non-load.
- Address bits above ADDR_W do not exist, so there is no out-of-range case; addresses wrap modulo 2^ADDR_W.

Optional Feature:
- Macro: DM_ALIGN_CHK_EN.
- Defined:
  - A halfword with addr[0]=1 or a word with addr[1:0]!=00 is misaligned.
  - The access is suppressed: no memory write.
  - err=1 for one cycle in the cycle after acceptance. For a load, rvalid=1 in that same cycle with rdata=0.
  - Aligned accesses behave exactly as in the undefined case.
- Undefined:
  - err is tied to 0.
  - Halfword ignores addr[0]; word ignores addr[1:0].

Test Plan:
- Reset, CLR_ON_RESET=1, ADDR_W=12 -> ready=0 for exactly 1024 cycles after rst_n rises, then 1; a word load at 0xFFC returns 0x00000000.
- Store word 0x11223344 @0x010; store byte 0xAB @0x011 -> word load @0x010 returns 0x1122AB44 on the cycle after acceptance, rvalid high for one cycle only.
- Store word 0x80FF7F01 @0x020 -> load byte @0x022: sign_ext=1 gives 0xFFFFFFFF, sign_ext=0 gives 0x000000FF; load half @0x022 with sign_ext=1 gives 0xFFFF80FF.
- Back-to-back loads @0x010, 0x020, 0x030 on three consecutive cycles -> three consecutive rvalid pulses with data in issue order; ready stays 1.
- Store to 0x040 immediately followed by a load of 0x040 -> new data returned.
- Assert rst_n=0 at clear index 500 -> clear restarts from 0. With DM_ALIGN_CHK_EN: word store @0x042 leaves memory unchanged and err pulses once; half load @0x041 gives rvalid=1, err=1, rdata=0.
